// File: rtl/stream_s2mm_capture_if.sv
// Stream-in / RAM-write-out bundle for the S2MM capture block.
// slave is the capture block's view, master the source/RAM side.
interface stream_s2mm_capture_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8,
  parameter int ADDR_W = 20
);
  logic [DATA_W-1:0] s_axis_tdata;
  logic [KEEP_W-1:0] s_axis_tkeep;
  logic              s_axis_tlast;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [KEEP_W-1:0] wr_strb;

  modport slave (
    input  s_axis_tdata,
    input  s_axis_tkeep,
    input  s_axis_tlast,
    input  s_axis_tvalid,
    output s_axis_tready,
    output wr_valid,
    output wr_addr,
    output wr_data,
    output wr_strb,
    input  wr_ready
  );

  modport master (
    output s_axis_tdata,
    output s_axis_tkeep,
    output s_axis_tlast,
    output s_axis_tvalid,
    input  s_axis_tready,
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  wr_strb,
    output wr_ready
  );
endinterface

// File: rtl/stream_s2mm_capture.sv
// AXI-Stream sink writing one frame of beats into a word-addressed RAM
// through a single registered write stage; checks tlast against length.
module stream_s2mm_capture #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = 8,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Control_start,
  input  logic [31:0]       Frame_Len,
  input  logic [ADDR_W-1:0] Base_Addr,
  stream_s2mm_capture_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic [31:0]       beat_count,
  output logic              err_early_last,
  output logic              err_no_last
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    FIN
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t state_q;
  state_t state_d;

  logic [31:0]       len_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              wvalid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [KEEP_W-1:0] strb_q;
  logic [31:0]       cnt_q;
  logic              early_q;
  logic              nolast_q;

  logic        start_ok;
  logic        tready;
  logic        accept;
  logic        term;
  logic        drained;
  logic [31:0] cnt_inc;

  assign cnt_inc  = cnt_q + 32'd1;
  assign start_ok = (state_q == IDLE) && Control_start;
  // Ready never looks at tvalid, so the source sees no comb loop.
  assign tready   = (state_q == RUN) && (!wvalid_q || bus.wr_ready);
  assign accept   = tready && bus.s_axis_tvalid;
  assign term     = accept && (bus.s_axis_tlast || cnt_inc == len_q);
  assign drained  = !wvalid_q || bus.wr_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (Control_start) begin
          state_d = (Frame_Len == 32'd0) ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (term) state_d = FLUSH;
      end
      FLUSH: begin
        if (drained) state_d = FIN;
      end
      FIN: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q    <= '0;
      ptr_q    <= '0;
      wvalid_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      cnt_q    <= '0;
      early_q  <= 1'b0;
      nolast_q <= 1'b0;
    end else begin
      if (start_ok) begin
        len_q    <= Frame_Len;
        ptr_q    <= Base_Addr;
        cnt_q    <= '0;
        early_q  <= 1'b0;
        nolast_q <= 1'b0;
      end
      if (accept) begin
        wvalid_q <= 1'b1;
        addr_q   <= ptr_q;
        data_q   <= bus.s_axis_tdata;
        strb_q   <= bus.s_axis_tkeep;
        ptr_q    <= ptr_q + ADDR_ONE;
        cnt_q    <= cnt_inc;
        if (bus.s_axis_tlast && cnt_inc < len_q) early_q <= 1'b1;
        if (!bus.s_axis_tlast && cnt_inc == len_q) nolast_q <= 1'b1;
      end else if (wvalid_q && bus.wr_ready) begin
        wvalid_q <= 1'b0;
      end
    end
  end

  assign bus.s_axis_tready = tready;
  assign bus.wr_valid      = wvalid_q;
  assign bus.wr_addr       = addr_q;
  assign bus.wr_data       = data_q;
  assign bus.wr_strb       = strb_q;

  assign busy           = (state_q == RUN) || (state_q == FLUSH);
  assign done           = (state_q == FIN);
  assign beat_count     = cnt_q;
  assign err_early_last = early_q;
  assign err_no_last    = nolast_q;

endmodule

// File: tb/tb_stream_s2mm_capture.sv
// Randomised scoreboard bench for stream_s2mm_capture: expected writes
// come from a frame-level model, a negedge monitor pops and compares.
module tb_stream_s2mm_capture;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int AW = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Control_start = 1'b0;
  logic [31:0]   Frame_Len = '0;
  logic [AW-1:0] Base_Addr = '0;
  logic          busy;
  logic          done;
  logic [31:0]   beat_count;
  logic          err_early_last;
  logic          err_no_last;

  stream_s2mm_capture_if #(.DATA_W(DW), .KEEP_W(KW), .ADDR_W(AW)) sif ();

  stream_s2mm_capture #(.DATA_W(DW), .KEEP_W(KW), .ADDR_W(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .Control_start  (Control_start),
    .Frame_Len      (Frame_Len),
    .Base_Addr      (Base_Addr),
    .bus            (sif),
    .busy           (busy),
    .done           (done),
    .beat_count     (beat_count),
    .err_early_last (err_early_last),
    .err_no_last    (err_no_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [KW-1:0] s;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] bq_d[$];
  logic [KW-1:0] bq_k[$];
  bit            bq_l[$];

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int n_wr = 0;
  int first_wr_cyc = 0;
  int last_wr_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard pops, stall-hold and backpressure checks.
  initial begin
    bit  prev_stall;
    wr_t prev_w;
    wr_t cur;
    wr_t e;
    prev_stall = 1'b0;
    prev_w = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        cur = '{a: sif.wr_addr, d: sif.wr_data, s: sif.wr_strb};
        if (prev_stall) begin
          chk("hold_valid", sif.wr_valid, 1);
          chk("hold_word", 64'(cur == prev_w), 1);
        end
        if (sif.wr_valid && !sif.wr_ready)
          chk("tready_stall", sif.s_axis_tready, 0);
        if (sif.wr_valid && sif.wr_ready) begin
          if (exp_q.size() == 0) begin
            chk("extra_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(sif.wr_addr), 64'(e.a));
            chk("wr_data", sif.wr_data, e.d);
            chk("wr_strb", 64'(sif.wr_strb), 64'(e.s));
          end
          if (n_wr == 0) first_wr_cyc = cyc;
          last_wr_cyc = cyc;
          n_wr++;
        end
        prev_stall = sif.wr_valid && !sif.wr_ready;
        prev_w = cur;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tready"}, sif.s_axis_tready, 0);
    chk({tag, "_wr_valid"}, sif.wr_valid, 0);
    chk({tag, "_wr_addr"}, 64'(sif.wr_addr), 0);
    chk({tag, "_wr_data"}, sif.wr_data, 0);
    chk({tag, "_wr_strb"}, 64'(sif.wr_strb), 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_beat_count"}, beat_count, 0);
    chk({tag, "_errs"}, {err_early_last, err_no_last}, 0);
  endtask

  // Builds a beat list, derives the expected frame outcome, and runs it.
  task automatic run_frame(input int len, input logic [AW-1:0] base,
                           input int nb, input int last_at,
                           input int rmode, input int vpct,
                           input bit start_on_done, input bit chk_lat);
    bit          fire;
    bit          seen;
    bit          e1;
    bit          e2;
    int          n;
    int          first_acc;
    int          start_c;
    int          done_c;
    int          rcnt;
    logic [31:0] bc;
    logic        g1;
    logic        g2;
    logic        gb;
    bq_d.delete();
    bq_k.delete();
    bq_l.delete();
    for (int i = 1; i <= nb; i++) begin
      bq_d.push_back({$urandom, $urandom});
      bq_k.push_back(KW'($urandom));
      bq_l.push_back(i == last_at);
    end
    n = 0;
    e1 = 1'b0;
    e2 = 1'b0;
    if (len > 0) begin
      for (int i = 1; i <= nb; i++) begin
        n = i;
        if (bq_l[i-1] || i == len) break;
      end
      e1 = bq_l[n-1] && (n < len);
      e2 = (n == len) && !bq_l[n-1];
    end
    for (int i = 0; i < n; i++)
      exp_q.push_back('{a: base + AW'(i), d: bq_d[i], s: bq_k[i]});
    n_wr = 0;
    Control_start = 1'b1;
    Frame_Len = 32'(len);
    Base_Addr = base;
    start_c = cyc;
    @(posedge clk);
    #1;
    Control_start = 1'b0;
    seen = 1'b0;
    first_acc = -1;
    done_c = 0;
    rcnt = 0;
    bc = '0;
    g1 = 1'b0;
    g2 = 1'b0;
    gb = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      if (bq_d.size() > 0 &&
          (sif.s_axis_tvalid || $urandom_range(99) < 32'(vpct))) begin
        sif.s_axis_tvalid = 1'b1;
        sif.s_axis_tdata  = bq_d[0];
        sif.s_axis_tkeep  = bq_k[0];
        sif.s_axis_tlast  = bq_l[0];
      end else begin
        sif.s_axis_tvalid = 1'b0;
      end
      case (rmode)
        0: sif.wr_ready = 1'b1;
        1: sif.wr_ready = (rcnt % 3 == 0);
        default: sif.wr_ready = 1'($urandom_range(1));
      endcase
      rcnt++;
      @(negedge clk);
      fire = sif.s_axis_tvalid && sif.s_axis_tready;
      if (fire && first_acc < 0) first_acc = cyc;
      if (done) begin
        seen = 1'b1;
        done_c = cyc;
        bc = beat_count;
        g1 = err_early_last;
        g2 = err_no_last;
        gb = busy;
        if (start_on_done) begin
          Control_start = 1'b1;
          Frame_Len = 32'd3;
        end
      end
      @(posedge clk);
      #1;
      Control_start = 1'b0;
      if (fire) begin
        void'(bq_d.pop_front());
        void'(bq_k.pop_front());
        void'(bq_l.pop_front());
      end
    end
    sif.s_axis_tvalid = 1'b0;
    sif.wr_ready = 1'b1;
    if (!seen) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("beat_count", bc, 32'(n));
      chk("err_early_last", g1, e1);
      chk("err_no_last", g2, e2);
      chk("busy_at_done", gb, 0);
      chk("writes_drained", exp_q.size(), 0);
      chk("beats_left", bq_d.size(), nb - n);
      if (chk_lat && n > 0) begin
        chk("first_wr_latency", 64'(first_wr_cyc - first_acc), 1);
        chk("done_latency", 64'(done_c - last_wr_cyc), 1);
      end
      if (chk_lat && n == 0)
        chk("done_latency_len0", 64'(done_c - start_c), 2);
    end
    exp_q.delete();
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_frame();
    int acc;
    bq_d.delete();
    for (int i = 0; i < 8; i++) begin
      bq_d.push_back({$urandom, $urandom});
      exp_q.push_back('{a: AW'(32'h40 + i), d: bq_d[i], s: 8'hFF});
    end
    Control_start = 1'b1;
    Frame_Len = 32'd8;
    Base_Addr = AW'(32'h40);
    @(posedge clk);
    #1;
    Control_start = 1'b0;
    acc = 0;
    sif.s_axis_tkeep = 8'hFF;
    sif.s_axis_tlast = 1'b0;
    sif.wr_ready = 1'b1;
    for (int k = 0; k < 50 && acc < 2; k++) begin
      sif.s_axis_tvalid = 1'b1;
      sif.s_axis_tdata = bq_d[0];
      @(negedge clk);
      if (sif.s_axis_tready) acc++;
      @(posedge clk);
      #1;
      if (acc > 0 && bq_d.size() > 0 && sif.wr_valid)
        void'(bq_d.pop_front());
    end
    chk("pre_reset_count", beat_count, 2);
    reset = 1'b1;
    #1;
    chk_reset_outputs("mid_reset");
    exp_q.delete();
    bq_d.delete();
    sif.s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int len;
    int nb;
    int la;
    sif.s_axis_tvalid = 1'b0;
    sif.s_axis_tdata = '0;
    sif.s_axis_tkeep = '0;
    sif.s_axis_tlast = 1'b0;
    sif.wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_frame(4, AW'(32'h100), 4, 4, 0, 100, 1'b0, 1'b1);
    run_frame(4, AW'(32'h100), 4, 4, 1, 100, 1'b0, 1'b0);
    run_frame(6, AW'(32'h100), 5, 3, 0, 100, 1'b0, 1'b0);
    run_frame(2, AW'(32'h100), 3, 0, 0, 100, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_last_sticky", err_no_last, 1);
    run_frame(4, AW'(32'hFFFFE), 4, 4, 0, 100, 1'b1, 1'b1);
    run_frame(0, AW'(32'h10), 2, 0, 0, 100, 1'b0, 1'b1);
    reset_mid_frame();
    run_frame(3, AW'(32'h200), 3, 3, 2, 70, 1'b0, 1'b0);
    for (int f = 0; f < 20; f++) begin
      len = int'($urandom_range(10, 1));
      nb = len + int'($urandom_range(2));
      la = int'($urandom_range(nb + 1));
      run_frame(len, AW'($urandom), nb, la, 2, 60, 1'b0, 1'b0);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stream_s2mm_capture.md
Name: stream_s2mm_capture

Overview:
- AXI-Stream sink for the Conv unit's output stream (m_axis_mm2s side); writes a frame of 64-bit beats into a word-addressed result RAM through a registered write port with backpressure.
- Used in benches and on-chip to collect convolution/layernorm output.
- Counts beats, checks tlast framing against a programmed length, and pulses done once the frame is committed.

Parameters:
- DATA_W, 64, stream and RAM data width in bits.
- KEEP_W, 8, tkeep/strobe width (DATA_W/8).
- ADDR_W, 20, RAM word-address width; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Control_start  in  1  one-cycle pulse; arms a new frame capture.
- Frame_Len  in  32  expected beat count; sampled on Control_start.
- Base_Addr  in  ADDR_W  first RAM word address; sampled on Control_start.
- s_axis_tdata  in  DATA_W  stream data.
- s_axis_tkeep  in  KEEP_W  byte enables; forwarded unchanged as wr_strb.
- s_axis_tlast  in  1  end-of-frame marker.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- wr_valid  out  1  RAM write request.
- wr_ready  in  1  RAM accepts write when high with wr_valid.
- wr_addr  out  ADDR_W  RAM word address.
- wr_data  out  DATA_W  RAM write data.
- wr_strb  out  KEEP_W  byte strobes.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at frame end.
- beat_count  out  32  beats accepted in the current or last frame.
- err_early_last  out  1  sticky until next start: tlast seen before beat Frame_Len.
- err_no_last  out  1  sticky until next start: beat Frame_Len arrived without tlast.

Behaviour:
- Reset (async): state IDLE; s_axis_tready=0, wr_valid=0, wr_addr=0, wr_data=0, wr_strb=0, busy=0, done=0, beat_count=0, both error flags 0.
- States:
  - IDLE: on Control_start, latch Frame_Len/Base_Addr, clear beat_count and errors. If Frame_Len==0, go to FLUSH (no writes; done next cycle); else go to RUN.
  - RUN: accepts beats. Transition to FLUSH after the terminating beat is accepted.
  - FLUSH: waits until the output register is empty (wr_valid=0, or wr_valid&&wr_ready this cycle), then pulses done for one cycle and returns to IDLE.
- Control_start outside IDLE is ignored.
- Handshake:
  - s_axis_tready = (state==RUN) && (!wr_valid || wr_ready). The register depth is one; there is no combinational path from tvalid to tready.
  - A beat is accepted when tvalid&&tready. In that case, next cycle: wr_valid=1, wr_data=tdata, wr_strb=tkeep, wr_addr=current pointer; the pointer increments (wraps at 2^ADDR_W); beat_count increments.
  - wr_valid clears on wr_valid&&wr_ready with no new accept.
  - wr_addr/wr_data/wr_strb hold stable while wr_valid && !wr_ready.
- Latency: accepted beat appears on the write port one cycle later.
- Frame termination: the terminating beat is the first accepted beat with tlast=1 or with beat_count+1==Frame_Len.
  - tlast with beat_count+1<Frame_Len: set err_early_last.
  - beat_count+1==Frame_Len and tlast=0: set err_no_last.
  - Both flags are updated in the same cycle as the accept. The terminating beat is still written.
- Beats arriving after termination are not accepted (tready=0). They remain for the next frame.
- busy=1 in RUN and FLUSH; done is asserted in the cycle FLUSH exits; busy falls in the same cycle as done.
- Reset mid-frame: immediate return to reset state; the pending write is discarded.
- Control_start in the same cycle as done: ignored (state is not yet IDLE).

Test Plan:
- Frame_Len=4, Base_Addr=0x100, continuous tvalid, tlast on beat 4, wr_ready=1 -> writes to 0x100..0x103 on consecutive cycles, first write 1 cycle after first accept; done 1 cycle after last write; beat_count=4; no errors.
- Same frame with wr_ready toggling 1,0,0,1… -> tready low while the register is full and unaccepted; wr_* held stable during stalls; all 4 data words written in order; none lost or duplicated.
- Frame_Len=6, tlast on beat 3 -> 3 writes (0x100..0x102), err_early_last=1, done pulse, beat_count=3; beat 4 not accepted (tready=0).
- Frame_Len=2, tlast never asserted -> 2 writes, err_no_last=1, done; next Control_start clears the flag.
- Base_Addr=0xFFFFE, Frame_Len=4 -> addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Frame_Len=0 -> no wr_valid, done 2 cycles after start. Separately, assert reset mid-frame after 2 beats -> all outputs return to reset values immediately, a later start runs a clean frame.
